// File: rtl/minibus_pkg.sv
// Shared minibus types: request/response structs, width encoding,
// default slave regions and the interconnect state enum.
package minibus_pkg;

    localparam logic [2:0] WIDTH_BYTE = 3'b000;
    localparam logic [2:0] WIDTH_HALF = 3'b001;
    localparam logic [2:0] WIDTH_WORD = 3'b010;

    localparam int         DEF_NUM_SLAVES = 2;
    localparam logic [3:0] REGION_RAM     = 4'h0;
    localparam logic [3:0] REGION_PERIPH  = 4'h1;
    // Element [i] is the addr[31:28] value owned by slave i.
    localparam logic [DEF_NUM_SLAVES-1:0][3:0] DEF_SLAVE_REGION = {REGION_PERIPH, REGION_RAM};

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  width;
        logic        wen;
        logic        ren;
    } minibus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ack;
        logic        err;
    } minibus_res_t;

    localparam minibus_res_t RES_ERR = '{rdata: 32'h0, ack: 1'b1, err: 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } ic_state_t;

    function automatic logic req_pending(minibus_req_t r);
        return r.wen | r.ren;
    endfunction

endpackage

// File: rtl/minibus_addr_decode.sv
// Combinational region decoder: addr[31:28] -> {hit, slave index}.
// When regions overlap the lowest-numbered slave wins.
module minibus_addr_decode
    import minibus_pkg::*;
#(
    parameter int                         NUM_SLAVES   = DEF_NUM_SLAVES,
    parameter logic [NUM_SLAVES-1:0][3:0] SLAVE_REGION = DEF_SLAVE_REGION,
    parameter int                         IDX_W        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [3:0]       region,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && (region == SLAVE_REGION[i])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/minibus_interconnect.sv
// Two-master, N-slave minibus interconnect: round-robin arbiter, region
// decode, IDLE/BUSY/ERR transaction FSM with timeout, response mux.
module minibus_interconnect
    import minibus_pkg::*;
#(
    parameter int                         NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter logic [NUM_SLAVES-1:0][3:0] SLAVE_REGION   = DEF_SLAVE_REGION,
    parameter int                         TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  minibus_req_t [1:0]             m_req,
    output minibus_res_t [1:0]             m_res,
    output logic [NUM_SLAVES-1:0]          s_sel,
    output minibus_req_t                   s_req,
    input  minibus_res_t [NUM_SLAVES-1:0]  s_res
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ic_state_t        state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       pend;
    logic             arb_sel;
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             timeout_hit;

    assign pend[0] = req_pending(m_req[0]);
    assign pend[1] = req_pending(m_req[1]);

    // On a tie the master not served last wins; otherwise whoever is pending.
    assign arb_sel = (pend == 2'b11) ? ~last_grant_q : pend[1];

    minibus_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .SLAVE_REGION(SLAVE_REGION),
        .IDX_W       (IDX_W)
    ) u_decode (
        .region(m_req[arb_sel].addr[31:28]),
        .hit   (dec_hit),
        .idx   (dec_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        s_sel        = '0;
        s_req        = '0;
        m_res        = '0;
        timeout_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|pend) begin
                    grant_d = arb_sel;
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    if (dec_hit && !(m_req[arb_sel].wen && m_req[arb_sel].ren)) begin
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end

            BUSY: begin
                timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
                // sel drops in the timeout cycle itself so the hung slave is released.
                if (!timeout_hit) begin
                    s_sel[idx_q] = 1'b1;
                    s_req        = m_req[grant_q];
                end
                if (s_res[idx_q].ack) begin
                    m_res[grant_q] = s_res[idx_q];
                    last_grant_d   = grant_q;
                    cnt_d          = '0;
                    state_d        = IDLE;
                end else if (timeout_hit) begin
                    m_res[grant_q] = RES_ERR;
                    last_grant_d   = grant_q;
                    cnt_d          = '0;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ERR: begin
                m_res[grant_q] = RES_ERR;
                last_grant_d   = grant_q;
                state_d        = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            idx_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_minibus_interconnect.sv
// Scoreboard bench: masters issue from queues, expected responses come from a
// region/memory reference model, a negedge monitor pops and compares.
module tb_minibus_interconnect;
    import minibus_pkg::*;

    localparam int NS = 2;
    localparam int TO = 16;

    typedef struct {
        minibus_req_t req;
        logic [31:0]  rdata;
        logic         err;
        int           issue;
    } exp_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    minibus_req_t [1:0]    m_req;
    minibus_res_t [1:0]    m_res;
    logic [NS-1:0]         s_sel;
    minibus_req_t          s_req;
    minibus_res_t [NS-1:0] s_res;

    always #5 clk = ~clk;

    minibus_interconnect #(
        .NUM_SLAVES    (NS),
        .SLAVE_REGION  (DEF_SLAVE_REGION),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .m_req(m_req),
        .m_res(m_res),
        .s_sel(s_sel),
        .s_req(s_req),
        .s_res(s_res)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sel_cycles = 0;
    int sel_rise_cyc = -1;
    logic [NS-1:0] sel_rise_val = '0;
    logic [NS-1:0] prev_sel = '0;
    logic prev_ack = 1'b0;
    logic hang1 = 1'b0;
    logic stray = 1'b0;

    minibus_req_t pendq [2][$];
    exp_t         expq [2][$];
    int           issue_log [2][$];
    int           ack_log [2][$];
    logic [1:0]   active = '0;
    logic [1:0]   acked = '0;

    logic [31:0] ram [NS][64];
    logic [31:0] ref_mem [NS][64];
    logic [NS-1:0] sack_q;
    logic [31:0] rdq [NS];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic minibus_req_t mk(input logic [31:0] a, input logic [31:0] d,
                                        input logic [2:0] w, input logic we, input logic re);
        minibus_req_t r;
        r.addr = a; r.wdata = d; r.width = w; r.wen = we; r.ren = re;
        return r;
    endfunction

    // Reference: region 0/1 map to slaves, anything else or wen&ren errors,
    // a hung slave 1 errors by timeout; reads return the current word.
    function automatic exp_t model(input minibus_req_t r);
        exp_t e;
        int rg;
        rg = int'(r.addr[31:28]);
        e.req   = r;
        e.issue = cyc;
        e.err   = (rg > 1) || (r.wen && r.ren) || (rg == 1 && hang1);
        e.rdata = (!e.err && r.ren) ? ref_mem[rg][r.addr[7:2]] : 32'h0;
        return e;
    endfunction

    function automatic void ref_write(input minibus_req_t r);
        int off;
        logic [31:0] low, mask, data;
        off  = (r.width == WIDTH_BYTE) ? int'(r.addr[1:0]) :
               (r.width == WIDTH_HALF) ? 2 * int'(r.addr[1]) : 0;
        low  = (r.width == WIDTH_BYTE) ? 32'hFF : (r.width == WIDTH_HALF) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = low << (8 * off);
        data = (r.wdata & low) << (8 * off);
        ref_mem[r.addr[28]][r.addr[7:2]] = (ref_mem[r.addr[28]][r.addr[7:2]] & ~mask) | data;
    endfunction

    // Slave models: registered-ready RAM, one ack per sel window; slave 1 can hang.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sack_q <= '0;
            for (int s = 0; s < NS; s++) rdq[s] <= 32'h0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (s_sel[s] && !sack_q[s] && !(s == 1 && hang1)) begin
                    sack_q[s] <= 1'b1;
                    rdq[s]    <= s_req.ren ? ram[s][s_req.addr[7:2]] : 32'h0;
                    if (s_req.wen) begin
                        case (s_req.width)
                            WIDTH_BYTE: ram[s][s_req.addr[7:2]][8*s_req.addr[1:0] +: 8] <= s_req.wdata[7:0];
                            WIDTH_HALF: ram[s][s_req.addr[7:2]][16*s_req.addr[1] +: 16] <= s_req.wdata[15:0];
                            default:    ram[s][s_req.addr[7:2]] <= s_req.wdata;
                        endcase
                    end
                end else begin
                    sack_q[s] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        s_res = '0;
        for (int s = 0; s < NS; s++) begin
            if (sack_q[s]) s_res[s] = '{rdata: rdq[s], ack: 1'b1, err: 1'b0};
        end
        // Stray ack from an unselected slave 1 must be ignored by the interconnect.
        if (stray && !s_sel[1]) s_res[1].ack = 1'b1;
    end

    // Master drivers: hold a request until its ack, then present the next one.
    minibus_req_t drv_t;
    always @(posedge clk) begin
        #1;
        if (!nrst) begin
            active = '0;
            acked  = '0;
            m_req  = '0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (active[m] && acked[m]) begin
                    active[m] = 1'b0;
                    acked[m]  = 1'b0;
                    m_req[m]  = '0;
                end
                if (!active[m] && pendq[m].size() != 0) begin
                    drv_t     = pendq[m].pop_front();
                    m_req[m]  = drv_t;
                    active[m] = 1'b1;
                    expq[m].push_back(model(drv_t));
                    issue_log[m].push_back(cyc);
                end
            end
        end
    end

    exp_t mon_e;
    logic mon_ack;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_ack = 1'b0;
            prev_sel = '0;
        end else begin
            check("sel_onehot", 128'($countones(s_sel) <= 1), 128'(1));
            if (prev_ack) check("sel_gap", 128'(s_sel), 128'(0));
            if (s_sel == '0) begin
                check("sreq_idle_zero", 128'(s_req), 128'(0));
            end else begin
                sel_cycles++;
                check("sreq_from_master",
                      128'((s_req == m_req[0] && active[0]) || (s_req == m_req[1] && active[1])), 128'(1));
            end
            if (s_sel != '0 && prev_sel == '0) begin
                sel_rise_cyc = cyc;
                sel_rise_val = s_sel;
            end
            prev_sel = s_sel;
            check("one_ack", 128'(m_res[0].ack && m_res[1].ack), 128'(0));
            mon_ack = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (m_res[m].ack) begin
                    mon_ack = 1'b1;
                    if (expq[m].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL spurious_ack m%0d: got ack with rdata %0h, required no ack (cycle %0d)",
                                 m, m_res[m].rdata, cyc);
                    end else begin
                        mon_e = expq[m].pop_front();
                        check($sformatf("m%0d_err", m), 128'(m_res[m].err), 128'(mon_e.err));
                        check($sformatf("m%0d_rdata", m), 128'(m_res[m].rdata), 128'(mon_e.rdata));
                        if (!mon_e.err && mon_e.req.wen) ref_write(mon_e.req);
                        ack_log[m].push_back(cyc);
                        acked[m] = 1'b1;
                    end
                end else begin
                    check($sformatf("m%0d_res_idle", m), 128'(m_res[m]), 128'(0));
                end
            end
            prev_ack = mon_ack;
        end
    end

    function automatic int ack_at(input int m, input int i);
        return (ack_log[m].size() > i) ? ack_log[m][i] : -1000;
    endfunction

    function automatic int issue_at(input int m, input int i);
        return (issue_log[m].size() > i) ? issue_log[m][i] : -2000;
    endfunction

    task automatic clear_logs();
        for (int m = 0; m < 2; m++) begin
            issue_log[m].delete();
            ack_log[m].delete();
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while ((pendq[0].size() + pendq[1].size() + expq[0].size() + expq[1].size()) != 0 || active != 2'b00) begin
            @(posedge clk); #2;
            n++;
            if (n > budget) begin
                tests++; fails++;
                $display("FAIL %s: transactions still open after %0d cycles, required all acked", name, budget);
                for (int m = 0; m < 2; m++) begin
                    pendq[m].delete();
                    expq[m].delete();
                end
                active = '0;
                m_req  = '0;
                break;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    function automatic minibus_req_t rnd_txn(input int m);
        int rsel, w, off, op, word;
        logic [3:0] rg;
        rsel = $urandom_range(0, 9);
        rg   = (rsel < 7) ? 4'h0 : (rsel < 9) ? 4'h1 : 4'($urandom_range(2, 15));
        w    = $urandom_range(0, 2);
        off  = (w == 0) ? $urandom_range(0, 3) : (w == 1) ? 2 * $urandom_range(0, 1) : 0;
        word = m * 32 + $urandom_range(0, 31);
        op   = $urandom_range(0, 19);
        return mk({rg, 20'h0, 6'(word), 2'(off)}, $urandom, 3'(w), op == 0 || op >= 10, op < 10);
    endfunction

    int t0, sc, nsel;
    initial begin
        m_req = '0;
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < 64; i++) begin
                ram[s][i]     = $urandom;
                ref_mem[s][i] = ram[s][i];
            end

        // Reset state
        @(negedge clk);
        check("rst_sel", 128'(s_sel), 128'(0));
        check("rst_sreq", 128'(s_req), 128'(0));
        check("rst_mres", 128'(m_res), 128'(0));
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // m1 word read from RAM
        clear_logs();
        ram[0][4] = 32'hDEADBEEF; ref_mem[0][4] = 32'hDEADBEEF;
        pendq[1].push_back(mk(32'h0000_0010, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(20, "rd_ram");
        check("rd_ram_lat", 128'(ack_at(1, 0) - issue_at(1, 0)), 128'(2));
        check("rd_ram_sel_cyc", 128'(sel_rise_cyc - issue_at(1, 0)), 128'(1));
        check("rd_ram_sel_val", 128'(sel_rise_val), 128'(2'b01));

        // Tie, then back-to-back re-request: alternation m0, m1, m0, m1
        clear_logs();
        pendq[0].push_back(mk(32'h0000_0000, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        pendq[0].push_back(mk(32'h0000_0004, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        pendq[1].push_back(mk(32'h0000_0008, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        pendq[1].push_back(mk(32'h1000_000C, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(40, "tie");
        t0 = issue_at(0, 0);
        check("tie_same_issue", 128'(issue_at(1, 0)), 128'(t0));
        check("tie_m0_first", 128'(ack_at(0, 0) - t0), 128'(2));
        check("tie_m1_second", 128'(ack_at(1, 0) - t0), 128'(5));
        check("tie2_m0", 128'(ack_at(0, 1) - t0), 128'(8));
        check("tie2_m1", 128'(ack_at(1, 1) - t0), 128'(11));

        // Decode errors: unmapped region and wen&ren on a mapped address
        clear_logs();
        sc = sel_cycles;
        pendq[0].push_back(mk(32'hF000_0000, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        pendq[0].push_back(mk(32'h0000_0020, 32'h5, WIDTH_WORD, 1'b1, 1'b1));
        wait_done(20, "dec_err");
        check("unmapped_lat", 128'(ack_at(0, 0) - issue_at(0, 0)), 128'(1));
        check("wenren_lat", 128'(ack_at(0, 1) - issue_at(0, 1)), 128'(1));
        check("dec_err_no_sel", 128'(sel_cycles - sc), 128'(0));

        // Hung slave 1 -> timeout, then a normal access
        clear_logs();
        hang1 = 1'b1;
        sc = sel_cycles;
        pendq[1].push_back(mk(32'h1000_0000, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(60, "timeout");
        hang1 = 1'b0;
        check("timeout_lat", 128'(ack_at(1, 0) - issue_at(1, 0)), 128'(TO));
        check("timeout_sel_cycles", 128'(sel_cycles - sc), 128'(TO - 1));
        pendq[1].push_back(mk(32'h1000_0004, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(20, "after_timeout");
        check("after_timeout_lat", 128'(ack_at(1, 1) - issue_at(1, 1)), 128'(2));

        // Stray acks from unselected slave 1 are dropped
        clear_logs();
        stray = 1'b1;
        repeat (3) @(negedge clk);
        pendq[0].push_back(mk(32'h0000_0014, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(20, "stray");
        stray = 1'b0;
        check("stray_lat", 128'(ack_at(0, 0) - issue_at(0, 0)), 128'(2));
        check("stray_one_ack", 128'(ack_log[0].size()), 128'(1));

        // Byte write: request held unchanged through the sel window
        clear_logs();
        nsel = 0;
        pendq[0].push_back(mk(32'h0000_0003, 32'h0000_00AB, WIDTH_BYTE, 1'b1, 1'b0));
        for (int i = 0; i < 12 && ack_log[0].size() == 0; i++) begin
            @(negedge clk);
            if (s_sel != '0) begin
                nsel++;
                check("bw_sreq", 128'(s_req), 128'(mk(32'h0000_0003, 32'h0000_00AB, WIDTH_BYTE, 1'b1, 1'b0)));
            end
        end
        wait_done(20, "bw");
        check("bw_sel_window", 128'(nsel), 128'(2));
        check("bw_lat", 128'(ack_at(0, 0) - issue_at(0, 0)), 128'(2));
        pendq[1].push_back(mk(32'h0000_0000, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(20, "bw_readback");

        // Reset mid-transaction aborts it without an ack
        clear_logs();
        pendq[0].push_back(mk(32'h0000_0008, 32'h1234_5678, WIDTH_WORD, 1'b1, 1'b0));
        for (int i = 0; i < 10 && s_sel == '0; i++) @(negedge clk);
        check("rstmid_sel_before", 128'(s_sel), 128'(2'b01));
        check("rstmid_wen_before", 128'(s_req.wen), 128'(1));
        nrst = 1'b0;
        #1;
        check("rstmid_sel_after", 128'(s_sel), 128'(0));
        check("rstmid_wen_after", 128'(s_req.wen), 128'(0));
        check("rstmid_no_ack", 128'(m_res), 128'(0));
        for (int m = 0; m < 2; m++) begin
            pendq[m].delete();
            expq[m].delete();
        end
        active = '0; acked = '0; m_req = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        clear_logs();
        pendq[0].push_back(mk(32'h0000_0008, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        pendq[1].push_back(mk(32'h1000_0008, 32'h0, WIDTH_WORD, 1'b0, 1'b1));
        wait_done(20, "post_rst");
        t0 = issue_at(0, 0);
        check("post_rst_m0_first", 128'(ack_at(0, 0) - t0), 128'(2));
        check("post_rst_m1_next", 128'(ack_at(1, 0) - t0), 128'(5));

        // Randomized traffic from both masters
        clear_logs();
        for (int i = 0; i < 200; i++) begin
            pendq[0].push_back(rnd_txn(0));
            pendq[1].push_back(rnd_txn(1));
        end
        wait_done(5000, "random");
        check("random_acks_m0", 128'(ack_log[0].size()), 128'(200));
        check("random_acks_m1", 128'(ack_log[1].size()), 128'(200));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        tests++; fails++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
